// File: rtl/lockin_pkg.sv
// -----------------------------------------------------------------------------
// lockin_pkg
// Shared definitions for the lock-in mixer:
//   PHASE_W      - width of the reference phase accumulator (32)
//   LFSR_W       - width of the phase-dither LFSR (16)
//   LFSR_SEED    - LFSR reset value (0xACE1)
//   LFSR_POLY    - Galois tap mask for x^16 + x^14 + x^13 + x^11 + 1
//   quarter_sine - elaboration-time helper that fills the quarter-wave table
//   lfsr_next    - one Galois LFSR step
//   scale_dither - aligns the LFSR value just below the LUT address bits
// -----------------------------------------------------------------------------
package lockin_pkg;

   localparam int PHASE_W = 32;
   localparam int LFSR_W  = 16;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   localparam logic [LFSR_W-1:0] LFSR_POLY = 16'hB400;

   localparam real PI = 3.14159265358979323846;

   // round(peak * sin(2*pi*k / 2^aw)) for a first-quadrant index k; always
   // non-negative, so rounding half-up is the same as half-away-from-zero.
   function automatic logic [31:0] quarter_sine(input int k, input int aw, input int dw);
      real peak;
      real x;
      peak = real'((longint'(1) << (dw - 1)) - longint'(1));
      x    = peak * $sin(2.0 * PI * real'(k) / real'(longint'(1) << aw));
      return 32'($rtoi(x + 0.5));
   endfunction

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_POLY : '0);
   endfunction

   // Places the LFSR MSB at the bit directly under the LUT address, so the
   // dither is always smaller than one LUT step and reaches the address only
   // through a carry out of the fractional phase bits.
   function automatic logic [PHASE_W-1:0] scale_dither(input logic [LFSR_W-1:0] v,
                                                      input int lut_aw);
      logic [PHASE_W-1:0] w;
      int                 frac;
      w    = PHASE_W'(v);
      frac = PHASE_W - lut_aw;
      if (frac >= LFSR_W) return w << (frac - LFSR_W);
      else                return w >> (LFSR_W - frac);
   endfunction

endpackage

// File: rtl/sine_lut.sv
// -----------------------------------------------------------------------------
// sine_lut
// Quarter-wave sine ROM with quadrant mirroring and a one-cycle registered
// read. Produces sin and cos of the same phase address.
// Parameters:
//   AW - phase address width (full cycle = 2^AW entries), AW >= 3
//   DW - signed output width, peak amplitude 2^(DW-1)-1
// Ports:
//   clk     - clock, rising edge
//   rst     - asynchronous active-high reset (clears output registers)
//   addr    - phase address
//   sin_out - registered sin(addr), one cycle after addr
//   cos_out - registered cos(addr) = sin(addr + 2^(AW-2))
// -----------------------------------------------------------------------------
module sine_lut
   import lockin_pkg::*;
#(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AW-1:0]        addr,
   output logic signed [DW-1:0] sin_out,
   output logic signed [DW-1:0] cos_out
);

   localparam int              QN      = 1 << (AW - 2);
   localparam logic [AW-1:0]   QUARTER = AW'(QN);
   localparam logic [AW-2:0]   QN_IDX  = (AW - 1)'(QN);

   // Entries 0..QN cover 0..pi/2 inclusive so the peak is stored exactly.
   // NOTE: this is a constant ROM built at elaboration; it is not state, so
   // it has no reset and costs nothing to leave uninitialised at power-up.
   logic [DW-1:0] qtab [0:QN];

   for (genvar k = 0; k <= QN; k++) begin : g_qtab
      localparam logic [DW-1:0] ENTRY = DW'(quarter_sine(k, AW, DW));
      assign qtab[k] = ENTRY;
   end

   // Odd quadrants run the table backwards; the address MSB selects the sign.
   function automatic logic [AW-2:0] fold(input logic [AW-2:0] a);
      logic [AW-2:0] off;
      off = {1'b0, a[AW-3:0]};
      return a[AW-2] ? (QN_IDX - off) : off;
   endfunction

   logic [AW-1:0]        cos_addr;
   logic [AW-2:0]        sin_idx;
   logic [AW-2:0]        cos_idx;
   logic signed [DW-1:0] sin_mag;
   logic signed [DW-1:0] cos_mag;

   // NOTE: every variable is assigned on every pass through this block, so
   // no path can leave one holding its old value and infer a latch.
   always_comb begin
      cos_addr = addr + QUARTER;
      sin_idx  = fold(addr[AW-2:0]);
      cos_idx  = fold(cos_addr[AW-2:0]);
      sin_mag  = $signed(qtab[sin_idx]);
      cos_mag  = $signed(qtab[cos_idx]);
   end

   // NOTE: non-blocking assignments in clocked logic so every register sees
   // the pre-edge value of every other register regardless of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sin_out <= '0;
         cos_out <= '0;
      end else begin
         sin_out <= addr[AW-1]     ? -sin_mag : sin_mag;
         cos_out <= cos_addr[AW-1] ? -cos_mag : cos_mag;
      end
   end

endmodule

// File: rtl/lockin_mixer.sv
// -----------------------------------------------------------------------------
// lockin_mixer
// Digital lock-in front end: multiplies each ADC sample by the cosine and
// sine of an NCO reference phase, giving full-precision I/Q products for a
// downstream CIC decimator.
//
// Pipeline (throughput one sample per clock, latency 3):
//   stage 1 - phase accumulator, lookup phase, LUT address, sample capture
//   stage 2 - registered sine/cos read (sine_lut)
//   stage 3 - signed multiply, output registers, tick
//
// Parameters:
//   ADC_W  - signed ADC sample width
//   LUT_AW - phase bits addressing the sine table (full cycle)
//   LUT_DW - signed sine amplitude width, peak 2^(LUT_DW-1)-1
//   OUT_W  - I/Q output width, must be >= ADC_W + LUT_DW
// Ports:
//   CLK       - clock, rising edge
//   RST       - asynchronous active-high reset
//   ADC_VALID - sample strobe, one cycle per sample
//   ADC_DATA  - signed sample, qualified by ADC_VALID
//   PHASE_INC - unsigned per-sample reference phase step
//   PHASE_OFS - phase offset added before lookup
//   tick      - one-cycle strobe marking new I_OUT/Q_OUT
//   I_OUT     - signed ADC_DATA * cos
//   Q_OUT     - signed ADC_DATA * sin
//
// Build option: define MIXER_PHASE_DITHER_EN to add LFSR phase dither in
// the fractional phase bits before truncation to the LUT address.
// -----------------------------------------------------------------------------
module lockin_mixer
   import lockin_pkg::*;
#(
   parameter int ADC_W  = 16,
   parameter int LUT_AW = 10,
   parameter int LUT_DW = 16,
   parameter int OUT_W  = 32
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    ADC_VALID,
   input  logic signed [ADC_W-1:0] ADC_DATA,
   input  logic [PHASE_W-1:0]      PHASE_INC,
   input  logic [PHASE_W-1:0]      PHASE_OFS,
   output logic                    tick,
   output logic signed [OUT_W-1:0] I_OUT,
   output logic signed [OUT_W-1:0] Q_OUT
);

   localparam int PROD_W     = ADC_W + LUT_DW;
   localparam int ADDR_SHIFT = PHASE_W - LUT_AW;

   if (OUT_W < PROD_W) begin : g_bad_out_w
      $error("lockin_mixer: OUT_W must be at least ADC_W + LUT_DW");
   end

   logic [PHASE_W-1:0]       acc;
   logic [PHASE_W-1:0]       lookup_phase;
   logic [LUT_AW-1:0]        lut_addr;

   logic                     s1_valid;
   logic [LUT_AW-1:0]        s1_addr;
   logic signed [ADC_W-1:0]  s1_data;

   logic                     s2_valid;
   logic signed [ADC_W-1:0]  s2_data;
   logic signed [LUT_DW-1:0] sin_val;
   logic signed [LUT_DW-1:0] cos_val;

   logic signed [PROD_W-1:0] prod_i;
   logic signed [PROD_W-1:0] prod_q;

   // ---------------------------------------------------------------- phase
   // The sample uses the accumulator value before this sample's increment,
   // so the first sample after reset sits at phase 0.
`ifdef MIXER_PHASE_DITHER_EN
   logic [LFSR_W-1:0] lfsr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)            lfsr <= LFSR_SEED;
      else if (ADC_VALID) lfsr <= lfsr_next(lfsr);
   end

   always_comb lookup_phase = acc + PHASE_OFS + scale_dither(lfsr, LUT_AW);
`else
   always_comb lookup_phase = acc + PHASE_OFS;
`endif

   always_comb lut_addr = LUT_AW'(lookup_phase >> ADDR_SHIFT);

   // -------------------------------------------------------------- stage 1
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         acc      <= '0;
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_data  <= '0;
      end else begin
         s1_valid <= ADC_VALID;
         if (ADC_VALID) begin
            acc     <= acc + PHASE_INC;
            s1_addr <= lut_addr;
            s1_data <= ADC_DATA;
         end
      end
   end

   // -------------------------------------------------------------- stage 2
   sine_lut #(
      .AW (LUT_AW),
      .DW (LUT_DW)
   ) u_sine_lut (
      .clk     (CLK),
      .rst     (RST),
      .addr    (s1_addr),
      .sin_out (sin_val),
      .cos_out (cos_val)
   );

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_data <= s1_data;
      end
   end

   // -------------------------------------------------------------- stage 3
   // Operands are widened to the full product width first, so even
   // -2^(ADC_W-1) * -peak is exact; no rounding or saturation anywhere.
   always_comb begin
      prod_i = PROD_W'(s2_data) * PROD_W'(cos_val);
      prod_q = PROD_W'(s2_data) * PROD_W'(sin_val);
   end

   // Outputs only move on a tick and hold their value in between.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tick  <= 1'b0;
         I_OUT <= '0;
         Q_OUT <= '0;
      end else begin
         tick <= s2_valid;
         if (s2_valid) begin
            I_OUT <= OUT_W'(prod_i);
            Q_OUT <= OUT_W'(prod_q);
         end
      end
   end

endmodule

// File: tb/tb_lockin_mixer.sv
// -----------------------------------------------------------------------------
// tb_lockin_mixer
// Self-checking bench for lockin_mixer. Directed scenarios compare against
// fixed expected products; the randomized scenario compares against a
// reference built from the NCO definition (phase accumulation plus a direct
// round(peak*sin) evaluation), including exact tick timing.
// -----------------------------------------------------------------------------
module tb_lockin_mixer;

   localparam int  ADC_W  = 16;
   localparam int  LUT_AW = 10;
   localparam int  LUT_DW = 16;
   localparam int  OUT_W  = 32;
   localparam int  N      = 1 << LUT_AW;
   localparam real PEAK   = 32767.0;
   localparam real TWO_PI = 6.283185307179586;

   logic                    CLK       = 1'b0;
   logic                    RST       = 1'b1;
   logic                    ADC_VALID = 1'b0;
   logic signed [ADC_W-1:0] ADC_DATA  = '0;
   logic [31:0]             PHASE_INC = '0;
   logic [31:0]             PHASE_OFS = '0;
   logic                    tick;
   logic signed [OUT_W-1:0] I_OUT;
   logic signed [OUT_W-1:0] Q_OUT;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   longint obs_i[$];
   longint obs_q[$];
   int     obs_cyc[$];
   longint exp_i[$];
   longint exp_q[$];
   int     exp_cyc[$];
   logic [31:0] model_acc = '0;

   lockin_mixer #(
      .ADC_W  (ADC_W),
      .LUT_AW (LUT_AW),
      .LUT_DW (LUT_DW),
      .OUT_W  (OUT_W)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .ADC_VALID (ADC_VALID),
      .ADC_DATA  (ADC_DATA),
      .PHASE_INC (PHASE_INC),
      .PHASE_OFS (PHASE_OFS),
      .tick      (tick),
      .I_OUT     (I_OUT),
      .Q_OUT     (Q_OUT)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Record every tick with its cycle number, sampled mid-cycle.
   always @(negedge CLK) begin
      if (tick === 1'b1) begin
         obs_i.push_back(longint'(I_OUT));
         obs_q.push_back(longint'(Q_OUT));
         obs_cyc.push_back(cyc);
      end
   end

   // ------------------------------------------------------------ reference
   function automatic longint ref_sin(input int k);
      real v;
      v = PEAK * $sin(TWO_PI * real'(k) / real'(N));
      if (v >= 0.0) return longint'($rtoi(v + 0.5));
      else          return -longint'($rtoi(0.5 - v));
   endfunction

   task automatic clear_queues();
      obs_i.delete(); obs_q.delete(); obs_cyc.delete();
      exp_i.delete(); exp_q.delete(); exp_cyc.delete();
   endtask

   // Drives one sample on the next cycle and records what it must produce.
   task automatic send(input logic signed [ADC_W-1:0] d, input logic [31:0] inc,
                       input logic [31:0] ofs);
      logic [31:0] ph;
      int          k;
      @(negedge CLK);
      ADC_VALID = 1'b1;
      ADC_DATA  = d;
      PHASE_INC = inc;
      PHASE_OFS = ofs;
      ph = model_acc + ofs;
      k  = int'(ph >> (32 - LUT_AW));
      exp_i.push_back(longint'(d) * ref_sin((k + N / 4) % N));
      exp_q.push_back(longint'(d) * ref_sin(k));
      exp_cyc.push_back(cyc + 3);
      model_acc = model_acc + inc;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge CLK);
         ADC_VALID = 1'b0;
      end
   endtask

   task automatic do_reset();
      @(negedge CLK);
      ADC_VALID = 1'b0;
      RST       = 1'b1;
      @(negedge CLK);
      clear_queues();
      model_acc = '0;
      RST       = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      n_checks++;
      if (tick !== 1'b0) begin
         n_fail++; $display("FAIL reset_tick: got %b want 0", tick);
      end
      n_checks++;
      if (I_OUT !== '0) begin
         n_fail++; $display("FAIL reset_i: got %0d want 0", I_OUT);
      end
      n_checks++;
      if (Q_OUT !== '0) begin
         n_fail++; $display("FAIL reset_q: got %0d want 0", Q_OUT);
      end
      RST = 1'b0;
      clear_queues();
      idle(3);
      n_checks++;
      if (obs_i.size() != 0) begin
         n_fail++; $display("FAIL reset_spurious_tick: got %0d ticks want 0", obs_i.size());
      end
   endtask

   task automatic test_single();
      do_reset();
      send(16'sd1000, 32'h0, 32'h0);
      idle(6);
      n_checks++;
      if (obs_i.size() != 1) begin
         n_fail++; $display("FAIL single_count: got %0d ticks want 1", obs_i.size());
      end else begin
         n_checks++;
         if (obs_cyc[0] != exp_cyc[0]) begin
            n_fail++; $display("FAIL single_latency: got cycle %0d want %0d", obs_cyc[0], exp_cyc[0]);
         end
         n_checks++;
         if (obs_i[0] != 64'sd32767000) begin
            n_fail++; $display("FAIL single_i: got %0d want 32767000", obs_i[0]);
         end
         n_checks++;
         if (obs_q[0] != 64'sd0) begin
            n_fail++; $display("FAIL single_q: got %0d want 0", obs_q[0]);
         end
      end
      // Outputs hold between ticks.
      n_checks++;
      if (I_OUT !== 32'sd32767000 || Q_OUT !== 32'sd0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL single_hold: got I=%0d Q=%0d tick=%b want I=32767000 Q=0 tick=0",
                  I_OUT, Q_OUT, tick);
      end
      // Sixteen constant-phase samples give identical products.
      clear_queues();
      for (int i = 0; i < 16; i++) send(16'sd1000, 32'h0, 32'h0);
      idle(6);
      n_checks++;
      if (obs_i.size() != 16) begin
         n_fail++; $display("FAIL const16_count: got %0d ticks want 16", obs_i.size());
      end
      for (int i = 0; i < 16 && i < obs_i.size(); i++) begin
         n_checks++;
         if (obs_i[i] != 64'sd32767000 || obs_q[i] != 64'sd0) begin
            n_fail++;
            $display("FAIL const16_%0d: got I=%0d Q=%0d want I=32767000 Q=0", i, obs_i[i], obs_q[i]);
         end
      end
   endtask

   task automatic test_quadrature();
      longint want_i [5] = '{32767000, 0, -32767000, 0, 32767000};
      longint want_q [5] = '{0, 32767000, 0, -32767000, 0};
      do_reset();
      for (int i = 0; i < 5; i++) send(16'sd1000, 32'h4000_0000, 32'h0);
      idle(6);
      n_checks++;
      if (obs_i.size() != 5) begin
         n_fail++; $display("FAIL quad_count: got %0d ticks want 5", obs_i.size());
      end
      for (int i = 0; i < 5 && i < obs_i.size(); i++) begin
         n_checks++;
         if (obs_i[i] != want_i[i] || obs_q[i] != want_q[i]) begin
            n_fail++;
            $display("FAIL quad_%0d: got I=%0d Q=%0d want I=%0d Q=%0d",
                     i, obs_i[i], obs_q[i], want_i[i], want_q[i]);
         end
      end
      if (obs_i.size() == 5) begin
         n_checks++;
         if (obs_i[4] != obs_i[0] || obs_q[4] != obs_q[0]) begin
            n_fail++;
            $display("FAIL quad_wrap: got I=%0d Q=%0d want I=%0d Q=%0d",
                     obs_i[4], obs_q[4], obs_i[0], obs_q[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int i = 0; i < 8; i++) send(-16'sd32768, 32'h0, 32'h8000_0000);
      idle(6);
      n_checks++;
      if (obs_i.size() != 8) begin
         n_fail++; $display("FAIL b2b_count: got %0d ticks want 8", obs_i.size());
      end
      for (int i = 0; i < 8 && i < obs_i.size(); i++) begin
         n_checks++;
         if (obs_i[i] != 64'sd1073709056 || obs_q[i] != 64'sd0 || obs_cyc[i] != exp_cyc[i]) begin
            n_fail++;
            $display("FAIL b2b_%0d: got I=%0d Q=%0d cycle=%0d want I=1073709056 Q=0 cycle=%0d",
                     i, obs_i[i], obs_q[i], obs_cyc[i], exp_cyc[i]);
         end
      end
   endtask

   task automatic test_reset_midflight();
      do_reset();
      send(16'sd1000, 32'h4000_0000, 32'h0);
      send(16'sd1000, 32'h4000_0000, 32'h0);
      @(negedge CLK);
      ADC_VALID = 1'b0;
      RST       = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      clear_queues();
      model_acc = '0;
      idle(6);
      n_checks++;
      if (obs_i.size() != 0) begin
         n_fail++; $display("FAIL midrst_ticks: got %0d ticks want 0", obs_i.size());
      end
      n_checks++;
      if (I_OUT !== '0 || Q_OUT !== '0) begin
         n_fail++; $display("FAIL midrst_outputs: got I=%0d Q=%0d want 0 0", I_OUT, Q_OUT);
      end
      send(16'sd1000, 32'h4000_0000, 32'h0);
      idle(6);
      n_checks++;
      if (obs_i.size() != 1) begin
         n_fail++; $display("FAIL midrst_next_count: got %0d ticks want 1", obs_i.size());
      end else begin
         n_checks++;
         if (obs_i[0] != 64'sd32767000 || obs_q[0] != 64'sd0) begin
            n_fail++;
            $display("FAIL midrst_next_phase0: got I=%0d Q=%0d want I=32767000 Q=0", obs_i[0], obs_q[0]);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0]             inc;
      logic [31:0]             ofs;
      logic signed [ADC_W-1:0] d;
      do_reset();
      inc = $urandom;
      ofs = $urandom;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0) inc = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 4096)) << 20;
         if ($urandom_range(0, 5) == 0) ofs = $urandom;
         case ($urandom_range(0, 7))
            0:       d = -16'sd32768;
            1:       d = 16'sd32767;
            default: d = ADC_W'($urandom);
         endcase
         send(d, inc, ofs);
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(6);
      n_checks++;
      if (obs_i.size() != exp_i.size()) begin
         n_fail++; $display("FAIL rand_count: got %0d ticks want %0d", obs_i.size(), exp_i.size());
      end
      for (int i = 0; i < exp_i.size() && i < obs_i.size(); i++) begin
         n_checks++;
         if (obs_i[i] != exp_i[i] || obs_q[i] != exp_q[i] || obs_cyc[i] != exp_cyc[i]) begin
            n_fail++;
            $display("FAIL rand_%0d: got I=%0d Q=%0d cycle=%0d want I=%0d Q=%0d cycle=%0d",
                     i, obs_i[i], obs_q[i], obs_cyc[i], exp_i[i], exp_q[i], exp_cyc[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_quadrature();
      test_back_to_back();
      test_reset_midflight();
`ifndef MIXER_PHASE_DITHER_EN
      test_random();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Safety net: the scenarios above take a few thousand cycles at most.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
